// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding, load-use stall and R15-write drain control for the 5-stage core.
// Build macro HAZARD_PERF_EN adds PerfClr plus saturating StallCount/FlushCount counters.
module hazard_unit #(
  parameter int RW     = 4,
  parameter int PC_REG = 15,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RW-1:0]     RA1D,
  input  logic [RW-1:0]     RA2D,
  input  logic [RW-1:0]     RA1E,
  input  logic [RW-1:0]     RA2E,
  input  logic [RW-1:0]     WA3E,
  input  logic [RW-1:0]     WA3M,
  input  logic [RW-1:0]     WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSD,
  input  logic              PCSrcE,
  input  logic              BranchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
`ifdef HAZARD_PERF_EN
  output logic              DrainBusy,
  input  logic              PerfClr,
  output logic [PERF_W-1:0] StallCount,
  output logic [PERF_W-1:0] FlushCount
`else
  output logic              DrainBusy
`endif
);

  localparam logic [RW-1:0] PC_IDX = RW'(PC_REG);

  // Each state names the pipeline stage currently holding the pending R15 write.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN_E = 2'd1,
    DRAIN_M = 2'd2,
    DRAIN_W = 2'd3
  } drain_state_t;

  drain_state_t state_r;
  logic         ldstall_s;
  logic         pend_s;

  // Memory stage wins over Writeback; PC writes are never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] ra,
    input logic          rw_m,
    input logic [RW-1:0] wa_m,
    input logic          rw_w,
    input logic [RW-1:0] wa_w
  );
    logic [1:0] sel;
    if (rw_m && (wa_m == ra) && (wa_m != PC_IDX)) begin
      sel = 2'b10;
    end else if (rw_w && (wa_w == ra) && (wa_w != PC_IDX)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection and the stall/flush/forward outputs; reset forces a flushed, idle pipeline.
  always_comb begin
    ldstall_s = MemtoRegE && RegWriteE && ((WA3E == RA1D) || (WA3E == RA2D));
    pend_s    = ((state_r == RUN) && PCSD) || (state_r == DRAIN_E) || (state_r == DRAIN_M);
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    DrainBusy = 1'b0;
    if (!reset) begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      DrainBusy = 1'b0;
    end else begin
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
      StallF    = ldstall_s || pend_s;
      StallD    = ldstall_s;
      FlushD    = pend_s || (state_r == DRAIN_W) || BranchTakenE;
      FlushE    = ldstall_s || BranchTakenE;
      DrainBusy = (state_r != RUN);
    end
  end

  // Drain FSM: a load-use stall or a taken branch defers entry, so the R15 write enters E only when D moves.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (PCSD && !ldstall_s && !BranchTakenE) begin
            state_r <= DRAIN_E;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN_E: begin
          if (PCSrcE) begin
            state_r <= DRAIN_M;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN_M: state_r <= DRAIN_W;
        DRAIN_W: state_r <= RUN;
        default: state_r <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt, input logic en);
    logic [PERF_W-1:0] nxt;
    if (en && (cnt != {PERF_W{1'b1}})) begin
      nxt = cnt + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      nxt = cnt;
    end
    return nxt;
  endfunction

  // Performance counters: clear beats increment, both stick at all-ones.
  always_ff @(posedge clk) begin
    if (!reset || PerfClr) begin
      StallCount <= {PERF_W{1'b0}};
      FlushCount <= {PERF_W{1'b0}};
    end else begin
      StallCount <= sat_inc(StallCount, StallF);
      FlushCount <= sat_inc(FlushCount, FlushE);
    end
  end
`endif

endmodule
